// File: rtl/rst_offset_pipe.sv
// Multi-channel offset pipeline: each accepted beat gets its channel's running count added,
// then travels through a DEPTH-stage stallable pipeline with valid/ready on both sides.
module rst_offset_pipe #(
    parameter int unsigned DW         = 8,
    parameter int unsigned CW         = 3,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned RESET_DATA = 1,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [$clog2(CHANNELS)-1:0] chan_i,
    input  logic [DW-1:0]               data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(CHANNELS)-1:0] chan_o,
    output logic [DW-1:0]               data_o
);

    localparam int unsigned CHW = $clog2(CHANNELS);

    logic                adv;
    logic                accept;
    logic [CW-1:0]       offset;
    logic [DW-1:0]       sum;

    logic [DEPTH-1:0]    valid_q;
    logic [DW-1:0]       data_q [DEPTH];
    logic [CHW-1:0]      chan_q [DEPTH];
    logic [CW-1:0]       cnt_q  [CHANNELS];
    logic [CW-1:0]       cnt_d  [CHANNELS];

    assign adv     = !valid_q[DEPTH-1] || ready_i;
    assign ready_o = adv && !rst;
    assign accept  = valid_i && ready_o;

    // Channel codes >= CHANNELS match no counter, so they get offset 0 and update nothing.
    always_comb begin
        offset = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_i == CHW'(c)) begin
                offset = cnt_q[c];
            end
        end
    end

    assign sum = data_i + DW'(offset);

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = cnt_q[c];
            if (accept && chan_i == CHW'(c)) begin
                if (SATURATE == 0 || cnt_q[c] != '1) begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
            // Clear wins over a same-cycle increment.
            if (clr_i) begin
                cnt_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (adv) begin
            valid_q[0] <= accept;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload registers only reset when RESET_DATA is set; otherwise they hold through reset.
    always_ff @(posedge clk) begin
        if (RESET_DATA != 0 && rst) begin
            data_q <= '{default: '0};
            chan_q <= '{default: '0};
        end else if (adv && !rst) begin
            data_q[0] <= sum;
            chan_q[0] <= chan_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                chan_q[i] <= chan_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
    assign chan_o  = chan_q[DEPTH-1];

endmodule

// File: doc/rst_offset_pipe.md
Name: rst_offset_pipe

Overview:
- Multi-channel, parametrised successor to the single-channel count-offset pipeline.
- Each accepted input beat is tagged with a channel; the beat's data is offset by that channel's running beat count.
- The result passes through a DEPTH-stage stallable pipeline with valid/ready handshakes on both sides.
- RESET_DATA selects full reset or control-only reset of the datapath, so both reset strategies can be compared from one block.

Parameters:
- DW, 8, data width of data_i/data_o.
- CW, 3, per-channel counter width (CW <= DW).
- CHANNELS, 4, number of independent counters (>= 2); CHW = clog2(CHANNELS).
- DEPTH, 2, pipeline stages input->output (>= 1).
- RESET_DATA, 1, 1: data/chan stage registers reset to 0; 0: only valid bits and counters reset.
- SATURATE, 0, 0: counters wrap mod 2^CW; 1: counters hold at 2^CW-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- clr_i  in  1  synchronous clear of all channel counters.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i && ready_o.
- chan_i  in  CHW  channel of input beat.
- data_i  in  DW  input data.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream ready.
- chan_o  out  CHW  channel of output beat.
- data_o  out  DW  data_i + offset, mod 2^DW.

Behaviour:
- Stall control:
  - adv = !valid_o || ready_i.
  - ready_o = adv && !rst (combinational).
  - When adv=1, all stages shift one position; stage 0 loads the accepted beat, or a bubble (valid=0) if nothing is accepted.
  - When adv=0, all stages hold. Bubbles are not collapsed.
- Latency: DEPTH cycles from acceptance to valid_o with no stall. Throughput is 1 beat/cycle while ready_i=1.
- Offset:
  - The beat carries count[chan_i] as sampled in its acceptance cycle (pre-increment), zero-extended to DW.
  - data_o = data_i + offset, truncated to DW; carry is discarded.
- Counter update on acceptance:
  - count[chan_i] += 1.
  - SATURATE=0: wraps 2^CW-1 -> 0.
  - SATURATE=1: stays at 2^CW-1.
  - Other channels are unchanged.
- chan_i >= CHANNELS (non-power-of-2 CHANNELS): the beat passes with offset 0 and no counter changes.
- clr_i:
  - All counters become 0 on the next edge.
  - If a beat is accepted in the same cycle, it uses the pre-clear count, and the counter ends at 0 (clear wins over increment).
  - clr_i does not touch beats already in the pipeline.
- Stalled output: valid_o, data_o and chan_o remain stable while valid_o && !ready_i.
- Reset:
  - All stage valids = 0, valid_o = 0, all counters = 0.
  - RESET_DATA=1: data_o = 0, chan_o = 0, all internal data/chan stages = 0.
  - RESET_DATA=0: data/chan registers keep their prior values. They are don't-care while the matching valid = 0, and the bench must not check them.
  - Inputs during rst are ignored. A reset asserted mid-stream drops all in-flight beats; there is no partial output.
- Edge-case requirements:
  - No X may propagate onto valid_o or ready_o in either RESET_DATA mode.
  - DEPTH=1 must work: stage 0 drives the outputs directly.

Test Plan:
- Defaults, ready_i=1, chan 0, data_i 10,10,10,...: data_o 10,11,12,...,17,10 (wraps after 8), first valid_o 2 cycles after the first accept.
- Interleave chans 0,1,0,1 with data_i=0x20 each: data_o 0x20,0x20,0x21,0x21; chan_o follows chan_i order.
- SATURATE=1, 10 beats on chan 2 with data_i=0: data_o 0,1,...,7,7,7.
- Backpressure: stream 6 beats, hold ready_i=0 for 3 cycles mid-stream:
  - ready_o=0 while the output is full.
  - valid_o/data_o stable throughout the stall.
  - No loss or duplication; order preserved.
- clr_i together with an accept on chan 0 at count=5: that beat's offset = 5; the next chan 0 beat's offset = 0.
- Reset mid-stream with pipeline full: valid_o=0 the cycle after rst. With RESET_DATA=1 data_o=0. Post-reset offsets restart at 0 and there are no stale beats.
